// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and saturation helpers for seq_arith_unit
package arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_MAC = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_ACC  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Largest positive value of a width-bit signed number; caller truncates to width.
    function automatic logic [127:0] sat_max_val(input int width);
        sat_max_val = (128'(1) << (width - 1)) - 128'(1);
    endfunction

    // Most negative value of a width-bit signed number; caller truncates to width.
    function automatic logic [127:0] sat_min_val(input int width);
        sat_min_val = 128'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// rtl/seq_mult_core.sv - unsigned radix-2 shift-add multiplier, one bit per cycle
module seq_mult_core #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_partial;

    // Partial product selected by the current multiplier LSB
    always_comb begin
        w_partial = r_mplier[0] ? r_mcand : '0;
    end

    // product already includes this cycle's partial, so the caller can take it
    // on the same edge that finishes the last iteration
    assign product = r_prod + w_partial;
    assign done    = r_busy && (r_cnt == '0);

    // Iteration state: load on start, then add/shift while counting down to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_mcand  <= {{WIDTH{1'b0}}, mcand};
            r_mplier <= mplier;
            r_prod   <= '0;
        end else if (r_busy) begin
            r_prod   <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// rtl/seq_arith_unit.sv - multi-cycle signed add/sub/mul/mac unit; ARITH_SAT_EN enables MAC saturation
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in1,
    input  logic [IN_WIDTH-1:0]  in2,
    input  logic [1:0]           op,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 ovf,
    output logic                 busy
);

    localparam int IMSB = IN_WIDTH - 1;
    localparam int OMSB = OUT_WIDTH - 1;

`ifdef ARITH_SAT_EN
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(sat_max_val(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(sat_min_val(OUT_WIDTH));
`endif

    state_t                r_state;
    op_t                   r_op;
    logic                  r_neg;
    logic                  r_clr;
    logic [OUT_WIDTH-1:0]  r_acc;
    logic [OUT_WIDTH-1:0]  r_prod;
    logic [OUT_WIDTH-1:0]  r_out;
    logic                  r_ovf;
    logic                  r_out_valid;
    logic                  r_busy;

    op_t                   w_op;
    logic                  w_accept;
    logic                  w_core_start;
    logic                  w_core_done;
    logic [2*IN_WIDTH-1:0] w_core_prod;
    logic [IN_WIDTH:0]     w_a_ext;
    logic [IN_WIDTH:0]     w_b_ext;
    logic [IN_WIDTH:0]     w_addsub;
    logic [OUT_WIDTH-1:0]  w_addsub_ext;
    logic [IN_WIDTH-1:0]   w_mag1;
    logic [IN_WIDTH-1:0]   w_mag2;
    logic [OUT_WIDTH-1:0]  w_mag_ext;
    logic [OUT_WIDTH-1:0]  w_signed_prod;
    logic [OUT_WIDTH-1:0]  w_acc_old;
    logic [OUT_WIDTH-1:0]  w_acc_sum;
    logic                  w_acc_ovf;
    logic [OUT_WIDTH-1:0]  w_acc_res;

    assign w_op      = op_t'(op);
    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = in_valid && in_ready;
    assign out       = r_out;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    // Exact IN_WIDTH+1-bit add/sub, then sign-extended to the result width
    always_comb begin
        w_a_ext      = {in1[IMSB], in1};
        w_b_ext      = {in2[IMSB], in2};
        w_addsub     = (w_op == OP_SUB) ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
        w_addsub_ext = {{(OUT_WIDTH-IN_WIDTH-1){w_addsub[IN_WIDTH]}}, w_addsub};
    end

    // Operand magnitudes as unsigned IN_WIDTH-bit values; 2^(IN_WIDTH-1) is
    // representable unsigned, so the most negative operand needs no special case
    always_comb begin
        w_mag1       = in1[IMSB] ? (IN_WIDTH'(0) - in1) : in1;
        w_mag2       = in2[IMSB] ? (IN_WIDTH'(0) - in2) : in2;
        w_core_start = w_accept && ((w_op == OP_MUL) || (w_op == OP_MAC));
    end

    seq_mult_core #(
        .WIDTH (IN_WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_core_start),
        .mcand   (w_mag1),
        .mplier  (w_mag2),
        .done    (w_core_done),
        .product (w_core_prod)
    );

    // Re-apply the product sign and form the accumulator sum with overflow detect
    always_comb begin
        w_mag_ext     = OUT_WIDTH'(w_core_prod);
        w_signed_prod = r_neg ? (OUT_WIDTH'(0) - w_mag_ext) : w_mag_ext;
        w_acc_old     = r_clr ? '0 : r_acc;
        w_acc_sum     = w_acc_old + r_prod;
        w_acc_ovf     = (w_acc_old[OMSB] == r_prod[OMSB]) && (w_acc_sum[OMSB] != w_acc_old[OMSB]);
`ifdef ARITH_SAT_EN
        w_acc_res     = w_acc_ovf ? (w_acc_old[OMSB] ? SAT_MIN : SAT_MAX) : w_acc_sum;
`else
        w_acc_res     = w_acc_sum;
`endif
    end

    // Control FSM with registered outputs and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_neg       <= 1'b0;
            r_clr       <= 1'b0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= w_op;
                        r_neg  <= in1[IMSB] ^ in2[IMSB];
                        r_clr  <= acc_clr;
                        r_busy <= 1'b1;
                        if ((w_op != OP_MAC) && acc_clr) begin
                            r_acc <= '0;
                        end
                        if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
                            r_out       <= w_addsub_ext;
                            r_ovf       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_core_done) begin
                        if (r_op == OP_MAC) begin
                            r_prod  <= w_signed_prod;
                            r_state <= ST_ACC;
                        end else begin
                            r_out       <= w_signed_prod;
                            r_ovf       <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_ACC: begin
                    r_out       <= w_acc_res;
                    r_acc       <= w_acc_res;
                    r_ovf       <= w_acc_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb/tb_seq_arith_unit.sv - directed self-checking bench for seq_arith_unit
module tb_seq_arith_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        acc_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in1 = 8'h00;
    logic [7:0]  in2 = 8'h00;
    logic [1:0]  op = 2'b00;
    logic        in_ready;
    logic        out_valid;
    logic        ovf;
    logic        busy;
    logic [15:0] out;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ARITH_SAT_EN
    localparam logic [15:0] MAC4_OUT = 16'h7FFF;
    localparam logic [15:0] MAC5_OUT = 16'h7FFF;
    localparam logic        MAC5_OVF = 1'b1;
`else
    localparam logic [15:0] MAC4_OUT = 16'h9C40;
    localparam logic [15:0] MAC5_OUT = 16'h9C41;
    localparam logic        MAC5_OVF = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_arith_unit #(
        .IN_WIDTH  (8),
        .OUT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                            input logic clr);
        in_valid = 1'b1;
        op       = o;
        in1      = a;
        in2      = b;
        acc_clr  = clr;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic clr, input int exp_lat,
                         input logic [15:0] exp_out, input logic exp_ovf);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        start_op(o, a, b, clr);
        wait_result(tag, exp_lat);
        check({tag, "_out"}, {16'd0, out}, {16'd0, exp_out});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        handshake(tag);
    endtask

    initial begin
        // reset values while rst_n is held low
        repeat (2) @(negedge clk);
        check("rst_out", {16'd0, out}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 100+100, output held under back-pressure
        start_op(2'b00, 8'd100, 8'd100, 1'b0);
        wait_result("add", 1);
        check("add_out", {16'd0, out}, 32'd200);
        check("add_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("add_hold_out", {16'd0, out}, 32'd200);
            check("add_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        handshake("add");

        // SUB -128-127 = -255, in_valid during DONE ignored
        start_op(2'b01, 8'h80, 8'h7F, 1'b0);
        wait_result("sub", 1);
        check("sub_out", {16'd0, out}, 32'h0000FF01);
        check("sub_ovf", {31'd0, ovf}, 32'd0);
        in_valid = 1'b1;
        op       = 2'b00;
        in1      = 8'd1;
        in2      = 8'd1;
        check("sub_done_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("sub_ignored_out", {16'd0, out}, 32'h0000FF01);
        check("sub_ignored_valid", {31'd0, out_valid}, 32'd1);
        handshake("sub");

        // MUL cases
        do_op("mul_m128", 2'b10, 8'h80, 8'h80, 1'b0, 9, 16'h4000, 1'b0);
        do_op("mul_m7x5", 2'b10, 8'hF9, 8'h05, 1'b0, 9, 16'hFFDD, 1'b0);

        // MAC 100x100 four times, cleared on the first
        do_op("mac1", 2'b11, 8'd100, 8'd100, 1'b1, 10, 16'd10000, 1'b0);
        do_op("mac2", 2'b11, 8'd100, 8'd100, 1'b0, 10, 16'd20000, 1'b0);
        do_op("mac3", 2'b11, 8'd100, 8'd100, 1'b0, 10, 16'd30000, 1'b0);
        do_op("mac4", 2'b11, 8'd100, 8'd100, 1'b0, 10, MAC4_OUT, 1'b1);

        // non-MAC without clear keeps the accumulator
        do_op("add_keep", 2'b00, 8'd1, 8'd1, 1'b0, 1, 16'd2, 1'b0);
        do_op("mac5", 2'b11, 8'd1, 8'd1, 1'b0, 10, MAC5_OUT, MAC5_OVF);

        // non-MAC with clear zeroes the accumulator
        do_op("sub_clr", 2'b01, 8'd5, 8'd7, 1'b1, 1, 16'hFFFE, 1'b0);
        do_op("mac6", 2'b11, 8'd2, 8'd3, 1'b0, 10, 16'd6, 1'b0);
        do_op("mac7", 2'b11, 8'hFD, 8'd4, 1'b0, 10, 16'hFFFA, 1'b0);

        // asynchronous reset 4 cycles into a MUL
        start_op(2'b10, 8'd9, 8'd9, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out", {16'd0, out}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ovf", {31'd0, ovf}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_discard_valid", {31'd0, out_valid}, 32'd0);
        check("arst_discard_busy", {31'd0, busy}, 32'd0);

        do_op("post_mul", 2'b10, 8'd3, 8'd4, 1'b0, 9, 16'd12, 1'b0);
        do_op("post_mac", 2'b11, 8'd1, 8'd1, 1'b0, 10, 16'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
